// File: rtl/uart_stream_source.sv
// uart_stream_source: byte source for uart_send.
// Two modes are available. The first sends a wrapping ASCII counting pattern.
// The second echoes bytes from uart_receive, with optional letter case swap.
// Echoed bytes pass through an internal FIFO.
// Optional build macro: UART_STREAM_CRLF_EN inserts CR/LF after each PAT_HI byte
// in pattern mode.
module uart_stream_source #(
    parameter int unsigned PAT_LO  = 48,
    parameter int unsigned PAT_HI  = 57,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic             CLK1,
    input  logic             RST,
    input  logic [1:0]       MODE,
    input  logic [7:0]       RX_DATA,
    input  logic             RX_READY,
    input  logic             SENDER_IDLE,
    output logic [7:0]       TX_DATA,
    output logic             TX_READY,
    output logic [FIFO_AW:0] FIFO_COUNT,
    output logic             OVERFLOW
);

    localparam int unsigned      DEPTH      = 2 ** FIFO_AW;
    localparam logic [7:0]       PAT_LO_B   = 8'(PAT_LO);
    localparam logic [7:0]       PAT_HI_B   = 8'(PAT_HI);
    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        READY,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_PAT  = 2'b01,
        MODE_ECHO = 2'b10,
        MODE_SWAP = 2'b11
    } mode_t;

`ifdef UART_STREAM_CRLF_EN
    typedef enum logic [1:0] {
        CRLF_NONE,
        CRLF_CR,
        CRLF_LF
    } crlf_t;

    crlf_t crlf, crlf_n;
`endif

    state_t             state, state_n;
    mode_t              mode_s;
    logic [7:0]         pat;
    logic               load;
    logic               adv_pat;
    logic [7:0]         load_data;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               rx_q, push_q;
    logic [7:0]         push_data_q;
    logic               pop, wr_en, full, empty;

    function automatic logic [7:0] swap_case(input logic [7:0] b);
        if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A))
            return b ^ 8'h20;
        return b;
    endfunction

    assign mode_s     = mode_t'(MODE);
    assign full       = (count == FULL_COUNT);
    assign empty      = (count == '0);
    // A push into a full FIFO still lands when a pop frees the head slot in the same cycle.
    assign wr_en      = push_q && (!full || pop);
    assign TX_READY   = (state == SEND);
    assign FIFO_COUNT = count;

    // Receive edge detect: register RX_READY and latch the byte, push on the following edge.
    always_ff @(posedge CLK1) begin
        if (RST) begin
            rx_q        <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            rx_q        <= RX_READY;
            push_q      <= RX_READY & ~rx_q;
            push_data_q <= RX_DATA;
        end
    end

    // FIFO storage write.
    always_ff @(posedge CLK1) begin
        if (wr_en)
            mem[wr_ptr] <= push_data_q;
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge CLK1) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop)
                count <= count + 1'b1;
            else if (!wr_en && pop)
                count <= count - 1'b1;
            if (push_q && full && !pop)
                OVERFLOW <= 1'b1;
        end
    end

    // Send FSM next-state, byte selection and FIFO pop.
    always_comb begin
        state_n   = state;
        load      = 1'b0;
        adv_pat   = 1'b0;
        pop       = 1'b0;
        load_data = pat;
`ifdef UART_STREAM_CRLF_EN
        crlf_n    = crlf;
`endif
        case (state)
            READY: begin
                if (SENDER_IDLE) begin
`ifdef UART_STREAM_CRLF_EN
                    if (crlf != CRLF_NONE) begin
                        load      = 1'b1;
                        load_data = (crlf == CRLF_CR) ? 8'h0D : 8'h0A;
                        crlf_n    = (crlf == CRLF_CR) ? CRLF_LF : CRLF_NONE;
                    end else begin
`endif
                    case (mode_s)
                        MODE_PAT: begin
                            load      = 1'b1;
                            adv_pat   = 1'b1;
                            load_data = pat;
`ifdef UART_STREAM_CRLF_EN
                            if (pat == PAT_HI_B)
                                crlf_n = CRLF_CR;
`endif
                        end
                        MODE_ECHO: begin
                            if (!empty) begin
                                load      = 1'b1;
                                pop       = 1'b1;
                                load_data = mem[rd_ptr];
                            end
                        end
                        MODE_SWAP: begin
                            if (!empty) begin
                                load      = 1'b1;
                                pop       = 1'b1;
                                load_data = swap_case(mem[rd_ptr]);
                            end
                        end
                        MODE_OFF: ;
                    endcase
`ifdef UART_STREAM_CRLF_EN
                    end
`endif
                end
                if (load)
                    state_n = SEND;
            end
            SEND:      state_n = WAIT_BUSY;
            WAIT_BUSY: if (!SENDER_IDLE) state_n = WAIT_DONE;
            WAIT_DONE: if (SENDER_IDLE) state_n = READY;
            default:   state_n = READY;
        endcase
    end

    // FSM state, output byte and pattern register.
    always_ff @(posedge CLK1) begin
        if (RST) begin
            state   <= READY;
            TX_DATA <= PAT_LO_B;
            pat     <= PAT_LO_B;
`ifdef UART_STREAM_CRLF_EN
            crlf    <= CRLF_NONE;
`endif
        end else begin
            state <= state_n;
            if (load)
                TX_DATA <= load_data;
            if (adv_pat)
                pat <= (pat == PAT_HI_B) ? PAT_LO_B : pat + 8'd1;
`ifdef UART_STREAM_CRLF_EN
            crlf  <= crlf_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_stream_source.sv
// Directed bench for uart_stream_source (default parameters).
// A transmitter model drops SENDER_IDLE 2 cycles after each strobe.
// It raises SENDER_IDLE again 20 cycles later.
`timescale 1ns/1ps
module tb_uart_stream_source;

    logic       CLK1 = 1'b0;
    logic       RST;
    logic [1:0] MODE;
    logic [7:0] RX_DATA;
    logic       RX_READY;
    logic       SENDER_IDLE;
    logic [7:0] TX_DATA;
    logic       TX_READY;
    logic [4:0] FIFO_COUNT;
    logic       OVERFLOW;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] sent_q[$];
    int         busy_t     = -1;
    int         bb_count   = 0;
    logic       prev_ready = 1'b0;

`ifdef UART_STREAM_CRLF_EN
    localparam int NPAT = 13;
`else
    localparam int NPAT = 11;
`endif

    uart_stream_source #(
        .PAT_LO (48),
        .PAT_HI (57),
        .FIFO_AW(4)
    ) dut (
        .CLK1       (CLK1),
        .RST        (RST),
        .MODE       (MODE),
        .RX_DATA    (RX_DATA),
        .RX_READY   (RX_READY),
        .SENDER_IDLE(SENDER_IDLE),
        .TX_DATA    (TX_DATA),
        .TX_READY   (TX_READY),
        .FIFO_COUNT (FIFO_COUNT),
        .OVERFLOW   (OVERFLOW)
    );

    always #5 CLK1 = ~CLK1;

    // Transmitter model and strobe logger, evaluated on the falling edge.
    initial begin
        SENDER_IDLE = 1'b1;
        forever begin
            @(negedge CLK1);
            if (busy_t >= 0) begin
                busy_t++;
                if (busy_t == 2)
                    SENDER_IDLE = 1'b0;
                if (busy_t == 22) begin
                    SENDER_IDLE = 1'b1;
                    busy_t      = -1;
                end
            end
            if (TX_READY === 1'b1) begin
                if (prev_ready)
                    bb_count++;
                sent_q.push_back(TX_DATA);
                busy_t = 0;
            end
            prev_ready = (TX_READY === 1'b1);
        end
    end

    task automatic push_byte(input logic [7:0] b);
        RX_DATA  = b;
        RX_READY = 1'b1;
        @(negedge CLK1);
        @(negedge CLK1);
        RX_READY = 1'b0;
        @(negedge CLK1);
    endtask

    task automatic wait_sent(input int n, input int budget, input string name);
        int c = 0;
        while (sent_q.size() < n && c < budget) begin
            @(negedge CLK1);
            c++;
        end
        n_vec++;
        if (sent_q.size() < n) begin
            n_err++;
            $display("FAIL %s: got %0d strobes, expected %0d", name, sent_q.size(), n);
        end
    endtask

    task automatic wait_quiet(input int budget, input string name);
        int q = 0;
        int c = 0;
        while (q < 4 && c < budget) begin
            @(negedge CLK1);
            c++;
            if (busy_t < 0 && SENDER_IDLE && TX_READY !== 1'b1) q++;
            else q = 0;
        end
        n_vec++;
        if (q < 4) begin
            n_err++;
            $display("FAIL %s: got still busy after %0d cycles, expected idle", name, c);
        end
    endtask

    task automatic test_reset();
        MODE     = 2'b00;
        RX_DATA  = 8'h00;
        RX_READY = 1'b0;
        RST      = 1'b1;
        repeat (3) @(negedge CLK1);
        n_vec++;
        if (TX_DATA !== 8'h30) begin n_err++; $display("FAIL reset_tx_data: got %h expected 30", TX_DATA); end
        n_vec++;
        if (TX_READY !== 1'b0) begin n_err++; $display("FAIL reset_tx_ready: got %b expected 0", TX_READY); end
        n_vec++;
        if (FIFO_COUNT !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", FIFO_COUNT); end
        n_vec++;
        if (OVERFLOW !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", OVERFLOW); end
        RST = 1'b0;
        @(negedge CLK1);
        n_vec++;
        if (TX_READY !== 1'b0) begin n_err++; $display("FAIL off_no_strobe: got %b expected 0", TX_READY); end
    endtask

    task automatic test_pattern();
        logic [7:0] exp [NPAT];
        logic [7:0] got;
`ifdef UART_STREAM_CRLF_EN
        exp = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h0D, 8'h0A, 8'h30};
`else
        exp = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h30};
`endif
        sent_q.delete();
        MODE = 2'b01;
        wait_sent(NPAT, 800, "pattern_wait");
        MODE = 2'b00;
        wait_quiet(100, "pattern_quiet");
        n_vec++;
        if (sent_q.size() != NPAT) begin
            n_err++;
            $display("FAIL pattern_strobes: got %0d expected %0d", sent_q.size(), NPAT);
        end
        for (int i = 0; i < NPAT; i++) begin
            got = (i < sent_q.size()) ? sent_q[i] : 8'hxx;
            n_vec++;
            if (got !== exp[i]) begin
                n_err++;
                $display("FAIL pattern_byte[%0d]: got %h expected %h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_echo();
        logic [7:0] exp [3];
        logic [7:0] got;
        exp = '{8'h41, 8'h7A, 8'h35};
        sent_q.delete();
        MODE = 2'b10;
        for (int i = 0; i < 3; i++) push_byte(exp[i]);
        wait_sent(3, 200, "echo_wait");
        wait_quiet(100, "echo_quiet");
        for (int i = 0; i < 3; i++) begin
            got = (i < sent_q.size()) ? sent_q[i] : 8'hxx;
            n_vec++;
            if (got !== exp[i]) begin
                n_err++;
                $display("FAIL echo_byte[%0d]: got %h expected %h", i, got, exp[i]);
            end
        end
        n_vec++;
        if (FIFO_COUNT !== 5'd0) begin n_err++; $display("FAIL echo_count: got %0d expected 0", FIFO_COUNT); end
        MODE = 2'b00;
    endtask

    task automatic test_case_swap();
        logic [7:0] din [8];
        logic [7:0] exp [8];
        logic [7:0] got;
        din = '{8'h41, 8'h7A, 8'h5B, 8'h35, 8'h40, 8'h60, 8'h5A, 8'h61};
        exp = '{8'h61, 8'h5A, 8'h5B, 8'h35, 8'h40, 8'h60, 8'h7A, 8'h41};
        sent_q.delete();
        MODE = 2'b11;
        for (int i = 0; i < 8; i++) push_byte(din[i]);
        wait_sent(8, 400, "swap_wait");
        wait_quiet(100, "swap_quiet");
        for (int i = 0; i < 8; i++) begin
            got = (i < sent_q.size()) ? sent_q[i] : 8'hxx;
            n_vec++;
            if (got !== exp[i]) begin
                n_err++;
                $display("FAIL swap_byte[%0d]: got %h expected %h", i, got, exp[i]);
            end
        end
        MODE = 2'b00;
    endtask

    task automatic test_overflow();
        logic [7:0] got;
        MODE = 2'b00;
        @(negedge CLK1);
        RX_DATA  = 8'h60;
        RX_READY = 1'b1;
        @(negedge CLK1);
        n_vec++;
        if (FIFO_COUNT !== 5'd0) begin n_err++; $display("FAIL rx_latency_1: got %0d expected 0", FIFO_COUNT); end
        @(negedge CLK1);
        n_vec++;
        if (FIFO_COUNT !== 5'd1) begin n_err++; $display("FAIL rx_latency_2: got %0d expected 1", FIFO_COUNT); end
        RX_READY = 1'b0;
        @(negedge CLK1);
        for (int i = 1; i < 16; i++) push_byte(8'(8'h60 + i));
        n_vec++;
        if (FIFO_COUNT !== 5'd16) begin n_err++; $display("FAIL full_count: got %0d expected 16", FIFO_COUNT); end
        n_vec++;
        if (OVERFLOW !== 1'b0) begin n_err++; $display("FAIL full_no_overflow: got %b expected 0", OVERFLOW); end
        push_byte(8'h70);
        n_vec++;
        if (FIFO_COUNT !== 5'd16) begin n_err++; $display("FAIL overflow_count: got %0d expected 16", FIFO_COUNT); end
        n_vec++;
        if (OVERFLOW !== 1'b1) begin n_err++; $display("FAIL overflow_flag: got %b expected 1", OVERFLOW); end
        sent_q.delete();
        MODE = 2'b10;
        wait_sent(16, 600, "overflow_wait");
        wait_quiet(100, "overflow_quiet");
        n_vec++;
        if (sent_q.size() != 16) begin n_err++; $display("FAIL overflow_sent: got %0d expected 16", sent_q.size()); end
        for (int i = 0; i < 16; i++) begin
            got = (i < sent_q.size()) ? sent_q[i] : 8'hxx;
            n_vec++;
            if (got !== 8'(8'h60 + i)) begin
                n_err++;
                $display("FAIL overflow_byte[%0d]: got %h expected %h", i, got, 8'(8'h60 + i));
            end
        end
        n_vec++;
        if (OVERFLOW !== 1'b1) begin n_err++; $display("FAIL overflow_sticky: got %b expected 1", OVERFLOW); end
        MODE = 2'b00;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] got;
        MODE = 2'b00;
        RST  = 1'b1;
        repeat (2) @(negedge CLK1);
        RST = 1'b0;
        n_vec++;
        if (OVERFLOW !== 1'b0) begin n_err++; $display("FAIL rst_clears_overflow: got %b expected 0", OVERFLOW); end
        for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i));
        sent_q.delete();
        RX_DATA  = 8'hA5;
        RX_READY = 1'b1;
        @(negedge CLK1);
        MODE = 2'b10;
        @(negedge CLK1);
        n_vec++;
        if (FIFO_COUNT !== 5'd16) begin n_err++; $display("FAIL pushpop_count: got %0d expected 16", FIFO_COUNT); end
        n_vec++;
        if (OVERFLOW !== 1'b0) begin n_err++; $display("FAIL pushpop_overflow: got %b expected 0", OVERFLOW); end
        n_vec++;
        if (TX_READY !== 1'b1 || TX_DATA !== 8'h80) begin
            n_err++;
            $display("FAIL pushpop_strobe: got %b/%h expected 1/80", TX_READY, TX_DATA);
        end
        RX_READY = 1'b0;
        wait_sent(17, 700, "pushpop_wait");
        wait_quiet(100, "pushpop_quiet");
        got = (sent_q.size() > 16) ? sent_q[16] : 8'hxx;
        n_vec++;
        if (got !== 8'hA5) begin n_err++; $display("FAIL pushpop_last: got %h expected a5", got); end
        got = (sent_q.size() > 15) ? sent_q[15] : 8'hxx;
        n_vec++;
        if (got !== 8'h8F) begin n_err++; $display("FAIL pushpop_16th: got %h expected 8f", got); end
        n_vec++;
        if (FIFO_COUNT !== 5'd0) begin n_err++; $display("FAIL pushpop_drain: got %0d expected 0", FIFO_COUNT); end
    endtask

    task automatic test_mode_change();
        logic [7:0] exp [3];
        logic [7:0] got;
        int c = 0;
        exp = '{8'h30, 8'h55, 8'h66};
        MODE = 2'b00;
        push_byte(8'h55);
        push_byte(8'h66);
        sent_q.delete();
        MODE = 2'b01;
        wait_sent(1, 20, "modechg_first");
        while (SENDER_IDLE !== 1'b0 && c < 20) begin
            @(negedge CLK1);
            c++;
        end
        repeat (3) @(negedge CLK1);
        MODE = 2'b10;
        wait_sent(3, 200, "modechg_wait");
        wait_quiet(100, "modechg_quiet");
        n_vec++;
        if (sent_q.size() != 3) begin n_err++; $display("FAIL modechg_strobes: got %0d expected 3", sent_q.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < sent_q.size()) ? sent_q[i] : 8'hxx;
            n_vec++;
            if (got !== exp[i]) begin
                n_err++;
                $display("FAIL modechg_byte[%0d]: got %h expected %h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int c = 0;
        MODE = 2'b00;
        for (int i = 0; i < 5; i++) push_byte(8'(8'h11 + i));
        n_vec++;
        if (FIFO_COUNT !== 5'd5) begin n_err++; $display("FAIL midrst_queued: got %0d expected 5", FIFO_COUNT); end
        MODE = 2'b10;
        while (TX_READY !== 1'b1 && c < 20) begin
            @(negedge CLK1);
            c++;
        end
        n_vec++;
        if (TX_READY !== 1'b1 || TX_DATA !== 8'h11) begin
            n_err++;
            $display("FAIL midrst_strobe: got %b/%h expected 1/11", TX_READY, TX_DATA);
        end
        @(negedge CLK1);
        RST = 1'b1;
        @(negedge CLK1);
        n_vec++;
        if (TX_DATA !== 8'h30) begin n_err++; $display("FAIL midrst_tx_data: got %h expected 30", TX_DATA); end
        n_vec++;
        if (TX_READY !== 1'b0) begin n_err++; $display("FAIL midrst_tx_ready: got %b expected 0", TX_READY); end
        n_vec++;
        if (FIFO_COUNT !== 5'd0) begin n_err++; $display("FAIL midrst_count: got %0d expected 0", FIFO_COUNT); end
        n_vec++;
        if (OVERFLOW !== 1'b0) begin n_err++; $display("FAIL midrst_overflow: got %b expected 0", OVERFLOW); end
        MODE = 2'b01;
        RST  = 1'b0;
        c    = 0;
        while (TX_READY !== 1'b1 && c < 60) begin
            @(negedge CLK1);
            c++;
        end
        n_vec++;
        if (TX_READY !== 1'b1 || SENDER_IDLE !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_first_strobe: got strobe=%b idle=%b expected 1/1", TX_READY, SENDER_IDLE);
        end
        n_vec++;
        if (TX_DATA !== 8'h30) begin n_err++; $display("FAIL midrst_pat: got %h expected 30", TX_DATA); end
        MODE = 2'b00;
        wait_quiet(100, "midrst_quiet");
    endtask

    task automatic test_strobe_rate();
        n_vec++;
        if (bb_count != 0) begin n_err++; $display("FAIL back_to_back: got %0d expected 0", bb_count); end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_echo();
        test_case_swap();
        test_overflow();
        test_full_push_pop();
        test_mode_change();
        test_reset_mid_op();
        test_strobe_rate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
